posit_mult: RTL and testbench

- Pipelined multiplier for posit numbers, default 32-bit with es=2, in the Pair-HMM posit datapath.
- Decodes both operands, multiplies significands, adds scales, then re-encodes with round-to-nearest-even.
- Flags NaR (inf) and zero results.
- Fully pipelined: one new operand pair may be issued every cycle.

---
 rtl/posit_pkg.sv | 23 ++
 rtl/posit_decode.sv | 30 +++
 rtl/posit_mult.sv | 69 ++++++
 tb/tb_posit_mult.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared widths, constants and decoded-operand type for the posit multiplier
package posit_pkg;
    localparam int N  = 32;
    localparam int ES = 2;
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(2 * (N - 2) * (1 << ES)) + 2;
    localparam int MW = N - ES - 2;
    localparam int PW = 2 * MW;
    localparam int FW = PW - 1;
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ZERO   = '0;
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = N'(1);
    localparam logic signed [SW-1:0] KMAX = SW'(N - 2);
    localparam logic signed [SW-1:0] KMIN = -KMAX;
    typedef struct packed {
        logic                 sign;
        logic                 nar;
        logic                 zero;
        logic signed [SW-1:0] scale;
        logic [MW-1:0]        sig;
    } posit_t;
endpackage

// File: rtl/posit_decode.sv
// posit_decode: combinational split of a posit into sign, scale and hidden-1 significand
module posit_decode
    import posit_pkg::*;
(
    input  logic [N-1:0] x,
    output posit_t       d
);
    logic [N-2:0] mag, rem;
    logic [CW-1:0] m;
    logic run, r0;
    logic signed [SW-1:0] k;
    always_comb begin
        mag = x[N-1] ? -x[N-2:0] : x[N-2:0];
        r0 = mag[N-2];
        m = '0;
        run = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            run = run & (mag[i] == r0);
            m = m + CW'(run);
        end
        // drop the regime run and its terminator; exponent then fraction are left-aligned
        rem = (mag << m) << 1;
        k = r0 ? SW'(m) - SW'(1) : -SW'(m);
        d.sign = x[N-1];
        d.nar = x == NAR;
        d.zero = x == ZERO;
        d.scale = (k <<< ES) + SW'(rem[N-2 -: ES]);
        d.sig = {1'b1, rem[N-2-ES -: MW-1]};
    end
endmodule

// File: rtl/posit_mult.sv
// posit_mult: pipelined posit multiplier, decode+multiply then encode+round-nearest-even.
// Define POSITMULT_OUTREG_EN to add an output register stage (latency 3 instead of 2).
module posit_mult
    import posit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         start,
    output logic [N-1:0] result,
    output logic         inf,
    output logic         zero,
    output logic         done
);
    localparam int VW = 2 + ES + FW + N;
    posit_t da, db;
    logic [PW-1:0] prod;
    logic v1, s1_sign, s1_nar, s1_zero;
    logic signed [SW-1:0] s1_scale, k2;
    logic [FW-1:0] s1_frac;
    logic [SW-1:0] sh;
    logic [VW-1:0] v;
    logic [N-1:0] rnd, mag, enc;
    logic guard, sticky;
    posit_decode u_da (.x(in1), .d(da));
    posit_decode u_db (.x(in2), .d(db));
    assign prod = PW'(da.sig) * PW'(db.sig);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {v1, s1_sign, s1_nar, s1_zero} <= '0;
            s1_scale <= '0;
            s1_frac <= '0;
        end else begin
            v1 <= start;
            s1_sign <= da.sign ^ db.sign;
            s1_nar <= da.nar | db.nar;
            s1_zero <= da.zero | db.zero;
            s1_scale <= da.scale + db.scale + SW'(prod[PW-1]);
            s1_frac <= prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        end
    // regime emitted by sign-extending shift: "10" grows a run of ones, "01" a run of zeros
    always_comb begin
        k2 = s1_scale >>> ES;
        sh = k2 < 0 ? ~k2 : k2;
        v = $signed({k2 < 0 ? 2'b01 : 2'b10, s1_scale[ES-1:0], s1_frac, N'(0)}) >>> sh;
        guard = v[VW-N];
        sticky = |v[VW-N-1:0];
        rnd = {1'b0, v[VW-1 -: N-1]} + N'(guard & (sticky | v[VW-N+1]));
        mag = k2 > KMAX ? MAXPOS : k2 < KMIN ? MINPOS : rnd[N-1] ? MAXPOS : rnd;
        enc = s1_nar ? NAR : s1_zero ? ZERO : s1_sign ? -mag : mag;
    end
`ifdef POSITMULT_OUTREG_EN
    logic [N-1:0] r2;
    logic i2, z2, d2;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {r2, i2, z2, d2} <= '0;
            {result, inf, zero, done} <= '0;
        end else begin
            {r2, i2, z2, d2} <= {enc, s1_nar, !s1_nar && s1_zero, v1};
            {result, inf, zero, done} <= {r2, i2, z2, d2};
        end
`else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {result, inf, zero, done} <= '0;
        else {result, inf, zero, done} <= {enc, s1_nar, !s1_nar && s1_zero, v1};
`endif
endmodule

// File: tb/tb_posit_mult.sv
// tb_posit_mult: scoreboard bench for posit_mult against a value-domain posit reference model
module tb_posit_mult;
`ifdef POSITMULT_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    typedef struct {
        logic [31:0] r;
        logic        i;
        logic        z;
        int          c;
        string       nm;
    } exp_t;

    logic clk = 0, rst_n = 0, start = 0;
    logic [31:0] in1 = 0, in2 = 0, result;
    logic inf, zero, done;
    int cyc = 0, n_vec = 0, n_err = 0;
    exp_t q[$];

    posit_mult dut (.clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .start(start),
                    .result(result), .inf(inf), .zero(zero), .done(done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // positive posit of width w (es=2) -> scale and left-aligned fraction, read bit by bit
    function automatic void pdec(input logic [32:0] b, input int w, output int sc, output logic [63:0] fr);
        int i, m, k, e, pos;
        logic r0;
        i = w - 2;
        r0 = b[i];
        m = 0;
        while (i >= 0 && b[i] == r0) begin m++; i--; end
        i--;
        k = r0 ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2;
            if (i >= 0) begin e += int'(b[i]); i--; end
        end
        fr = '0;
        pos = 63;
        while (i >= 0) begin fr[pos] = b[i]; pos--; i--; end
        sc = k * 4 + e;
    endfunction

    function automatic int vcmp(input int sa, input logic [63:0] fa, input int sb, input logic [63:0] fb);
        if (sa != sb) return sa < sb ? -1 : 1;
        if (fa != fb) return fa < fb ? -1 : 1;
        return 0;
    endfunction

    // exact product, then the nearest posit found by searching the monotonic encoding;
    // the tie point between p and p+1 is the 33-bit posit {p,1}
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] ma, mb, lo, hi, mid, r;
        logic [63:0] fa, fb, xf, pf;
        logic [55:0] p;
        int sa, sb, xs, ps, c;
        e.nm = "rand";
        e.c = 0;
        if (a == 32'h80000000 || b == 32'h80000000) begin
            e.r = 32'h80000000; e.i = 1; e.z = 0;
        end else if (a == 0 || b == 0) begin
            e.r = 0; e.i = 0; e.z = 1;
        end else begin
            ma = a[31] ? -a : a;
            mb = b[31] ? -b : b;
            pdec({1'b0, ma}, 32, sa, fa);
            pdec({1'b0, mb}, 32, sb, fb);
            p = {28'b0, 1'b1, fa[63:37]} * {28'b0, 1'b1, fb[63:37]};
            xs = sa + sb + int'(p[55]);
            xf = p[55] ? {p[54:0], 9'b0} : {p[53:0], 10'b0};
            pdec({1'b0, 32'd1}, 32, ps, pf);
            if (vcmp(ps, pf, xs, xf) > 0) r = 32'd1;
            else begin
                lo = 1;
                hi = 32'h7FFFFFFF;
                while (lo < hi) begin
                    mid = lo + (hi - lo + 1) / 2;
                    pdec({1'b0, mid}, 32, ps, pf);
                    if (vcmp(ps, pf, xs, xf) <= 0) lo = mid; else hi = mid - 1;
                end
                r = lo;
                if (r != 32'h7FFFFFFF) begin
                    pdec({r, 1'b1}, 33, ps, pf);
                    c = vcmp(xs, xf, ps, pf);
                    if (c > 0 || (c == 0 && r[0])) r = r + 1;
                end
            end
            e.r = (a[31] ^ b[31]) ? -r : r;
            e.i = 0;
            e.z = 0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_posit();
        logic [31:0] x;
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0) return 32'h0;
        if (sel == 1) return 32'h80000000;
        if (sel == 2) return 32'h7FFFFFFF;
        if (sel == 3) return 32'h00000001;
        x = $urandom >> $urandom_range(0, 30);
        if ($urandom_range(0, 1) == 1) x = ~x;
        x = {1'b0, x[30:0]};
        return $urandom_range(0, 1) == 1 ? -x : x;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(posedge clk);
        #1;
        in1 = a;
        in2 = b;
        start = 1;
        e.c = cyc;
        q.push_back(e);
    endtask

    task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic i, input logic z, input string nm);
        exp_t e;
        e.r = r; e.i = i; e.z = z; e.c = 0; e.nm = nm;
        drive(a, b, e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic check_quiet(input string nm);
        n_vec++;
        if (done !== 0 || result !== 0 || inf !== 0 || zero !== 0) begin
            n_err++;
            $display("FAIL %s: got done=%b result=%h inf=%b zero=%b, want all zero", nm, done, result, inf, zero);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_done: done=1 result=%h with no operation outstanding", result);
            end else begin
                e = q.pop_front();
                if (result !== e.r || inf !== e.i || zero !== e.z || cyc != e.c + LAT) begin
                    n_err++;
                    $display("FAIL %s: got result=%h inf=%b zero=%b cycle=%0d, want result=%h inf=%b zero=%b cycle=%0d",
                             e.nm, result, inf, zero, cyc, e.r, e.i, e.z, e.c + LAT);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset_state");
        rst_n = 1;
        dir(32'h001CCD95, 32'h001CCD95, 32'h00000CE2, 0, 0, "square_a");
        dir(32'h00364F61, 32'h00364F61, 32'h00002CCC, 0, 0, "square_b");
        dir(32'h40000000, 32'hC0000000, 32'hC0000000, 0, 0, "one_x_minus_one");
        dir(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, "maxpos_sat");
        dir(32'h00000001, 32'h00000001, 32'h00000001, 0, 0, "minpos_floor");
        dir(32'h00000000, 32'h12345678, 32'h00000000, 0, 1, "zero_operand");
        dir(32'h80000000, 32'h00000000, 32'h80000000, 1, 0, "nar_x_zero");
        idle();
        repeat (4) idle();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            a = rnd_posit();
            b = rnd_posit();
            drive(a, b, model(a, b));
        end
        for (int n = 0; n < 3; n++) begin
            a = rnd_posit();
            b = rnd_posit();
            e = model(a, b);
            e.nm = "pre_reset";
            drive(a, b, e);
        end
        @(posedge clk);
        #3;
        rst_n = 0;
        start = 0;
        #1;
        check_quiet("async_reset");
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (4) idle();
        for (int n = 0; n < 60; n++) begin
            a = rnd_posit();
            b = rnd_posit();
            e = model(a, b);
            e.nm = "post_reset";
            drive(a, b, e);
        end
        idle();
        for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results still outstanding, want 0", q.size());
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
